// File: rtl/mult_div_if.sv
// Request/response bundle between the datapath control and the multiply/divide unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_rs_data;
  logic [WIDTH-1:0] i_rt_data;
  logic             i_mthi;
  logic             i_mtlo;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_busy;
  logic             o_done;
  logic             o_div_by_zero;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_rs_data, i_rt_data, i_mthi, i_mtlo, i_wr_data,
    input  o_busy, o_done, o_div_by_zero, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_rs_data, i_rt_data, i_mthi, i_mtlo, i_wr_data,
    output o_busy, o_done, o_div_by_zero, o_hi, o_lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Signed ops run on magnitudes; the FIX state restores signs before HI/LO are written.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t r_state, w_nextState;

  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [WIDTH-1:0]   r_accHi, r_accLo, r_operand;
  logic [CW-1:0]      r_count;
  logic               r_isDiv, r_negQ, r_negR, r_divZero;

  logic               w_busy, w_done, w_accept, w_mtAllowed;
  logic               w_signedOp, w_rsNeg, w_rtNeg;
  logic [WIDTH-1:0]   w_rsMag, w_rtMag;
  logic [WIDTH:0]     w_mulSum, w_divShift;
  logic [WIDTH-1:0]   w_divDiff;
  logic               w_divFits;
  logic [2*WIDTH-1:0] w_prod, w_prodFix;
  logic [WIDTH-1:0]   w_quotFix, w_remFix;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (bus.i_start) w_nextState = S_CALC;
      S_CALC: begin
        w_busy = 1'b1;
        if (r_count == LAST) w_nextState = S_FIX;
      end
      S_FIX: begin
        w_busy      = 1'b1;
        w_nextState = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_nextState = bus.i_start ? S_CALC : S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_accept    = bus.i_start & ~w_busy;
  assign w_mtAllowed = ~w_busy & ~bus.i_start;

  assign w_signedOp = ~bus.i_op[0];
  assign w_rsNeg    = w_signedOp & bus.i_rs_data[WIDTH-1];
  assign w_rtNeg    = w_signedOp & bus.i_rt_data[WIDTH-1];
  assign w_rsMag    = w_rsNeg ? -bus.i_rs_data : bus.i_rs_data;
  assign w_rtMag    = w_rtNeg ? -bus.i_rt_data : bus.i_rt_data;

  // Multiply keeps the multiplier in accLo and shifts the running product in from the top.
  assign w_mulSum   = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_operand} : '0);
  assign w_divShift = {r_accHi, r_accLo[WIDTH-1]};
  assign w_divFits  = (w_divShift >= {1'b0, r_operand});
  assign w_divDiff  = w_divShift[WIDTH-1:0] - r_operand;

  assign w_prod    = {r_accHi, r_accLo};
  assign w_prodFix = r_negQ ? -w_prod : w_prod;
  assign w_quotFix = r_divZero ? '1 : (r_negQ ? -r_accLo : r_accLo);
  assign w_remFix  = r_negR ? -r_accHi : r_accHi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_operand <= '0;
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_isDiv   <= bus.i_op[1];
        r_negQ    <= w_rsNeg ^ w_rtNeg;
        r_negR    <= bus.i_op[1] & w_rsNeg;
        r_divZero <= (bus.i_rt_data == '0);
        r_count   <= '0;
        r_accHi   <= '0;
        r_accLo   <= bus.i_op[1] ? w_rsMag : w_rtMag;
        r_operand <= bus.i_op[1] ? w_rtMag : w_rsMag;
      end else if (r_state == S_CALC) begin
        r_count <= r_count + 1'b1;
        if (r_isDiv) begin
          r_accHi <= w_divFits ? w_divDiff : w_divShift[WIDTH-1:0];
          r_accLo <= {r_accLo[WIDTH-2:0], w_divFits};
        end else begin
          r_accHi <= w_mulSum[WIDTH:1];
          r_accLo <= {w_mulSum[0], r_accLo[WIDTH-1:1]};
        end
      end

      // Architectural HI/LO change only on result write-back or an honoured move.
      if (r_state == S_FIX) begin
        if (r_isDiv) begin
          r_hi <= w_remFix;
          r_lo <= w_quotFix;
        end else begin
          r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
          r_lo <= w_prodFix[WIDTH-1:0];
        end
      end else if (w_mtAllowed) begin
        if (bus.i_mthi) r_hi <= bus.i_wr_data;
        if (bus.i_mtlo) r_lo <= bus.i_wr_data;
      end
    end
  end

  assign bus.o_busy        = w_busy;
  assign bus.o_done        = w_done;
  assign bus.o_div_by_zero = w_done & r_isDiv & r_divZero;
  assign bus.o_hi          = r_hi;
  assign bus.o_lo          = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  localparam int         W        = 32;
  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   misses  = 0;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference results straight from signed/unsigned integer arithmetic.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                   output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    int          a;
    int          b;
    longint      sp;
    logic [63:0] up;
    a   = rs;
    b   = rt;
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      OP_MULT: begin
        sp = longint'(a) * longint'(b);
        {hi, lo} = sp;
      end
      OP_MULTU: begin
        up = {32'b0, rs} * {32'b0, rt};
        {hi, lo} = up;
      end
      default: begin
        if (rt == 32'h0) begin
          lo  = 32'hFFFF_FFFF;
          hi  = rs;
          dbz = 1'b1;
        end else if (op == OP_DIVU) begin
          lo = rs / rt;
          hi = rs % rt;
        end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          lo = rs;
          hi = 32'h0;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      misses++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.i_start   = 1'b1;
    bus.i_op      = op;
    bus.i_rs_data = rs;
    bus.i_rt_data = rt;
    @(negedge clk);
    bus.i_start   = 1'b0;
    bus.i_op      = 2'($urandom);
    bus.i_rs_data = $urandom;
    bus.i_rt_data = $urandom;
  endtask

  task automatic waitAndCheck(input string tag, input int startCycle, input logic [31:0] expHi,
                              input logic [31:0] expLo, input logic expDbz);
    int          cycles;
    logic        moved;
    logic [31:0] hi0;
    logic [31:0] lo0;
    cycles = startCycle;
    moved  = 1'b0;
    hi0    = bus.o_hi;
    lo0    = bus.o_lo;
    while (!bus.o_done && cycles < 100) begin
      if (bus.o_hi !== hi0 || bus.o_lo !== lo0) moved = 1'b1;
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " latency"}, 64'(cycles), 64'(34));
    checkOutput({tag, " stable"}, 64'(moved), 64'(0));
    checkOutput({tag, " hi"}, 64'(bus.o_hi), 64'(expHi));
    checkOutput({tag, " lo"}, 64'(bus.o_lo), 64'(expLo));
    checkOutput({tag, " dbz"}, 64'(bus.o_div_by_zero), 64'(expDbz));
    checkOutput({tag, " busy@done"}, 64'(bus.o_busy), 64'(0));
  endtask

  task automatic finishOp(input string tag);
    @(negedge clk);
    checkOutput({tag, " done pulse"}, 64'(bus.o_done), 64'(0));
    checkOutput({tag, " dbz pulse"}, 64'(bus.o_div_by_zero), 64'(0));
    checkOutput({tag, " idle"}, 64'(bus.o_busy), 64'(0));
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] expHi, input logic [31:0] expLo, input logic expDbz);
    applyStimulus(op, rs, rt);
    waitAndCheck(tag, 1, expHi, expLo, expDbz);
    finishOp(tag);
  endtask

  initial begin
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic        mDbz;
    logic [31:0] loPrev;
    logic [1:0]  rop;
    logic [31:0] rrs;
    logic [31:0] rrt;
    int          sel;
    int          dones;

    reset         = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_op      = 2'd0;
    bus.i_rs_data = '0;
    bus.i_rt_data = '0;
    bus.i_mthi    = 1'b0;
    bus.i_mtlo    = 1'b0;
    bus.i_wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset hi", 64'(bus.o_hi), 64'(0));
    checkOutput("reset lo", 64'(bus.o_lo), 64'(0));
    checkOutput("reset busy", 64'(bus.o_busy), 64'(0));
    checkOutput("reset done", 64'(bus.o_done), 64'(0));
    checkOutput("reset dbz", 64'(bus.o_div_by_zero), 64'(0));

    bus.i_mtlo    = 1'b1;
    bus.i_wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.i_mtlo = 1'b0;
    checkOutput("mtlo lo", 64'(bus.o_lo), 64'(32'hDEAD_BEEF));
    checkOutput("mtlo hi", 64'(bus.o_hi), 64'(0));

    bus.i_mthi    = 1'b1;
    bus.i_mtlo    = 1'b1;
    bus.i_wr_data = 32'h1357_9BDF;
    @(negedge clk);
    bus.i_mthi = 1'b0;
    bus.i_mtlo = 1'b0;
    checkOutput("mthilo hi", 64'(bus.o_hi), 64'(32'h1357_9BDF));
    checkOutput("mthilo lo", 64'(bus.o_lo), 64'(32'h1357_9BDF));

    applyStimulus(OP_MULT, 32'd1234, 32'd5678);
    repeat (8) @(negedge clk);
    checkOutput("abort busy", 64'(bus.o_busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort hi", 64'(bus.o_hi), 64'(0));
    checkOutput("abort lo", 64'(bus.o_lo), 64'(0));
    checkOutput("abort busy0", 64'(bus.o_busy), 64'(0));
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    checkOutput("abort no done", 64'(dones), 64'(0));

    runOp("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    runOp("mult -3*7", OP_MULT, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    runOp("mult -3*-7", OP_MULT, -32'sd3, -32'sd7, 32'h0, 32'd21, 1'b0);
    runOp("div -7/2", OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("div 7/-2", OP_DIV, 32'd7, -32'sd2, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    runOp("divu big/3", OP_DIVU, 32'h8000_0000, 32'd3, 32'h0000_0002, 32'h2AAA_AAAA, 1'b0);
    runOp("div 5/0", OP_DIV, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    runOp("div -5/0", OP_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    runOp("divu x/0", OP_DIVU, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
    runOp("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    runOp("mult minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);

    bus.i_mthi    = 1'b1;
    bus.i_wr_data = 32'hAAAA_5555;
    @(negedge clk);
    bus.i_mthi = 1'b0;
    checkOutput("mthi idle", 64'(bus.o_hi), 64'(32'hAAAA_5555));
    applyStimulus(OP_MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_op      = OP_DIVU;
    bus.i_rs_data = 32'd100;
    bus.i_rt_data = 32'd7;
    bus.i_mthi    = 1'b1;
    bus.i_wr_data = 32'h1234_5678;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_mthi  = 1'b0;
    checkOutput("mthi busy", 64'(bus.o_hi), 64'(32'hAAAA_5555));
    checkOutput("restart busy", 64'(bus.o_busy), 64'(1));
    waitAndCheck("ignored start", 6, 32'h0, 32'd15, 1'b0);
    finishOp("ignored start");
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    checkOutput("no queued op", 64'(dones), 64'(0));

    loPrev        = bus.o_lo;
    bus.i_mtlo    = 1'b1;
    bus.i_wr_data = 32'hCAFE_BABE;
    applyStimulus(OP_DIVU, 32'd1000, 32'd7);
    bus.i_mtlo = 1'b0;
    checkOutput("mtlo w/ start", 64'(bus.o_lo), 64'(loPrev));
    waitAndCheck("op beats mtlo", 1, 32'd6, 32'd142, 1'b0);
    finishOp("op beats mtlo");

    applyStimulus(OP_MULT, 32'd100, -32'sd9);
    waitAndCheck("b2b first", 1, 32'hFFFF_FFFF, 32'hFFFF_FC7C, 1'b0);
    applyStimulus(OP_DIV, -32'sd100, 32'd9);
    checkOutput("b2b no done", 64'(bus.o_done), 64'(0));
    checkOutput("b2b busy", 64'(bus.o_busy), 64'(1));
    checkOutput("b2b hold lo", 64'(bus.o_lo), 64'(32'hFFFF_FC7C));
    waitAndCheck("b2b second", 1, 32'hFFFF_FFFF, 32'hFFFF_FFF5, 1'b0);
    finishOp("b2b second");

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      rrs = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      rrt = 32'h0;
      else if (sel < 3)  rrt = 32'($urandom_range(1, 15));
      else if (sel == 3) rrt = -32'($urandom_range(1, 15));
      else               rrt = $urandom;
      refModel(rop, rrs, rrt, mHi, mLo, mDbz);
      runOp($sformatf("rand%0d op%0d", i, rop), rop, rrs, rrt, mHi, mLo, mDbz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
